// File: rtl/bram_quad_frontend.sv
// rtl/bram_quad_frontend.sv - two-lane request/response front-end for a quad-port block RAM

module bram_quad_lane #(
    parameter int DATA_WIDTH = 32,
    parameter int RSP_DEPTH  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rd_fire,
    input  logic                  fwd_hit,
    input  logic [DATA_WIDTH-1:0] fwd_value,
    input  logic [DATA_WIDTH-1:0] ram_do,
    output logic                  req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data
);

    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(RSP_DEPTH - 1);

    logic                  inflight;
    logic                  fwd;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
    logic [CW-1:0]         occ;
    logic                  push;
    logic                  pop;

    // The read issued last cycle lands in the FIFO now; the RAM's 1-cycle latency is absorbed here.
    assign push      = inflight;
    assign pop       = rsp_valid && rsp_ready;
    assign occ       = count + {{(CW-1){1'b0}}, inflight};
    // Ready depends only on registered state, so rsp_ready never reaches req_ready combinationally.
    assign req_ready = (occ < DEPTH_C);
    assign rsp_valid = (count != '0);
    assign rsp_data  = mem[rd_ptr];

    // Track the read in flight and capture any same-cycle cross-lane write data for forwarding.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inflight <= 1'b0;
            fwd      <= 1'b0;
            fwd_data <= '0;
        end else begin
            inflight <= rd_fire;
            fwd      <= rd_fire && fwd_hit;
            fwd_data <= fwd_value;
        end
    end

    // Circular FIFO pointers and occupancy; credits guarantee a push never finds it full.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // FIFO storage; forwarded data replaces the RAM output when a write collided with this read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= fwd ? fwd_data : ram_do;
        end
    end

endmodule

module bram_quad_frontend #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int RSP_DEPTH  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_write,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_data,
    output logic                  a_rsp_valid,
    input  logic                  a_rsp_ready,
    output logic [DATA_WIDTH-1:0] a_rsp_data,
    output logic [ADDR_WIDTH-1:0] a_ram_rd_addr,
    output logic [ADDR_WIDTH-1:0] a_ram_wr_addr,
    output logic [DATA_WIDTH-1:0] a_ram_di,
    output logic                  a_ram_we,
    output logic                  a_ram_re,
    input  logic [DATA_WIDTH-1:0] a_ram_do,
    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_write,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_data,
    output logic                  b_rsp_valid,
    input  logic                  b_rsp_ready,
    output logic [DATA_WIDTH-1:0] b_rsp_data,
    output logic [ADDR_WIDTH-1:0] b_ram_rd_addr,
    output logic [ADDR_WIDTH-1:0] b_ram_wr_addr,
    output logic [DATA_WIDTH-1:0] b_ram_di,
    output logic                  b_ram_we,
    output logic                  b_ram_re,
    input  logic [DATA_WIDTH-1:0] b_ram_do
);

    logic a_fire, b_fire;
    logic a_rd, a_wr, b_rd, b_wr;
    logic same_addr;
    logic a_fwd_hit, b_fwd_hit;

    assign a_fire    = a_req_valid && a_req_ready;
    assign b_fire    = b_req_valid && b_req_ready;
    assign a_rd      = a_fire && !a_req_write;
    assign a_wr      = a_fire &&  a_req_write;
    assign b_rd      = b_fire && !b_req_write;
    assign b_wr      = b_fire &&  b_req_write;
    assign same_addr = (a_req_addr == b_req_addr);

    // A read colliding with the other lane's write returns that write's data (write-first).
    assign a_fwd_hit = a_rd && b_wr && same_addr;
    assign b_fwd_hit = b_rd && a_wr && same_addr;

    assign a_ram_re      = a_rd;
    assign a_ram_rd_addr = a_req_addr;
    assign a_ram_we      = a_wr;
    assign a_ram_wr_addr = a_req_addr;
    assign a_ram_di      = a_req_data;

    // Lane A wins a same-address double write; lane B's request is still accepted but suppressed.
    assign b_ram_re      = b_rd;
    assign b_ram_rd_addr = b_req_addr;
    assign b_ram_we      = b_wr && !(a_wr && same_addr);
    assign b_ram_wr_addr = b_req_addr;
    assign b_ram_di      = b_req_data;

    bram_quad_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .RSP_DEPTH  (RSP_DEPTH)
    ) u_lane_a (
        .clock     (clock),
        .reset     (reset),
        .rd_fire   (a_rd),
        .fwd_hit   (a_fwd_hit),
        .fwd_value (b_req_data),
        .ram_do    (a_ram_do),
        .req_ready (a_req_ready),
        .rsp_valid (a_rsp_valid),
        .rsp_ready (a_rsp_ready),
        .rsp_data  (a_rsp_data)
    );

    bram_quad_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .RSP_DEPTH  (RSP_DEPTH)
    ) u_lane_b (
        .clock     (clock),
        .reset     (reset),
        .rd_fire   (b_rd),
        .fwd_hit   (b_fwd_hit),
        .fwd_value (a_req_data),
        .ram_do    (b_ram_do),
        .req_ready (b_req_ready),
        .rsp_valid (b_rsp_valid),
        .rsp_ready (b_rsp_ready),
        .rsp_data  (b_rsp_data)
    );

endmodule

// File: tb/tb_bram_quad_frontend.sv
// tb/tb_bram_quad_frontend.sv - directed self-checking bench for bram_quad_frontend

module tb_bram_quad_frontend;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          a_req_valid, a_req_ready, a_req_write;
    logic [AW-1:0] a_req_addr;
    logic [DW-1:0] a_req_data;
    logic          a_rsp_valid, a_rsp_ready;
    logic [DW-1:0] a_rsp_data;
    logic [AW-1:0] a_ram_rd_addr, a_ram_wr_addr;
    logic [DW-1:0] a_ram_di, a_ram_do;
    logic          a_ram_we, a_ram_re;
    logic          b_req_valid, b_req_ready, b_req_write;
    logic [AW-1:0] b_req_addr;
    logic [DW-1:0] b_req_data;
    logic          b_rsp_valid, b_rsp_ready;
    logic [DW-1:0] b_rsp_data;
    logic [AW-1:0] b_ram_rd_addr, b_ram_wr_addr;
    logic [DW-1:0] b_ram_di, b_ram_do;
    logic          b_ram_we, b_ram_re;

    int checks = 0;
    int errors = 0;

    bram_quad_frontend #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(3)) dut (
        .clock(clock), .reset(reset),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_write(a_req_write),
        .a_req_addr(a_req_addr), .a_req_data(a_req_data),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_data(a_rsp_data),
        .a_ram_rd_addr(a_ram_rd_addr), .a_ram_wr_addr(a_ram_wr_addr), .a_ram_di(a_ram_di),
        .a_ram_we(a_ram_we), .a_ram_re(a_ram_re), .a_ram_do(a_ram_do),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_write(b_req_write),
        .b_req_addr(b_req_addr), .b_req_data(b_req_data),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_data(b_rsp_data),
        .b_ram_rd_addr(b_ram_rd_addr), .b_ram_wr_addr(b_ram_wr_addr), .b_ram_di(b_ram_di),
        .b_ram_we(b_ram_we), .b_ram_re(b_ram_re), .b_ram_do(b_ram_do)
    );

    always #5 clock = ~clock;

    // RAM model: 1-cycle read latency; a read colliding with a same-cycle write yields X.
    logic [DW-1:0] ram [1024];
    always @(posedge clock) begin
        if (a_ram_re)
            a_ram_do <= ((a_ram_we && a_ram_wr_addr == a_ram_rd_addr) ||
                         (b_ram_we && b_ram_wr_addr == a_ram_rd_addr)) ? 'x : ram[a_ram_rd_addr];
        if (b_ram_re)
            b_ram_do <= ((a_ram_we && a_ram_wr_addr == b_ram_rd_addr) ||
                         (b_ram_we && b_ram_wr_addr == b_ram_rd_addr)) ? 'x : ram[b_ram_rd_addr];
        if (a_ram_we && b_ram_we && a_ram_wr_addr == b_ram_wr_addr)
            ram[a_ram_wr_addr] <= 'x;
        else begin
            if (a_ram_we) ram[a_ram_wr_addr] <= a_ram_di;
            if (b_ram_we) ram[b_ram_wr_addr] <= b_ram_di;
        end
    end

    // Credit monitor: outstanding reads per lane must never exceed 3 when a new read is accepted.
    int out_a = 0;
    int out_b = 0;
    always @(negedge clock) begin
        if (!reset) begin
            out_a = 0;
            out_b = 0;
        end else begin
            if (a_req_valid && a_req_ready && !a_req_write) begin
                checks++;
                if (out_a >= 3) begin
                    errors++;
                    $display("FAIL credit_a: outstanding=%0d required<3", out_a);
                end
                out_a++;
            end
            if (b_req_valid && b_req_ready && !b_req_write) begin
                checks++;
                if (out_b >= 3) begin
                    errors++;
                    $display("FAIL credit_b: outstanding=%0d required<3", out_b);
                end
                out_b++;
            end
            if (a_rsp_valid && a_rsp_ready) out_a--;
            if (b_rsp_valid && b_rsp_ready) out_b--;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_a(input logic v, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        a_req_valid = v; a_req_write = w; a_req_addr = ad; a_req_data = d;
    endtask

    task automatic set_b(input logic v, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        b_req_valid = v; b_req_write = w; b_req_addr = ad; b_req_data = d;
    endtask

    task automatic test_reset();
        set_a(0, 0, '0, '0);
        set_b(0, 0, '0, '0);
        a_rsp_ready = 1'b1;
        b_rsp_ready = 1'b1;
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        checks++;
        if ({a_req_ready, b_req_ready} !== 2'b11) begin
            errors++;
            $display("FAIL reset_ready: got=%b required=11", {a_req_ready, b_req_ready});
        end
        checks++;
        if ({a_rsp_valid, b_rsp_valid, a_ram_we, b_ram_we, a_ram_re, b_ram_re} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got=%b required=000000",
                     {a_rsp_valid, b_rsp_valid, a_ram_we, b_ram_we, a_ram_re, b_ram_re});
        end
    endtask

    task automatic test_write_read();
        step();
        set_a(1, 1, 10'd5, 32'hDEADBEEF);
        #1;
        checks++;
        if (a_req_ready !== 1'b1 || a_ram_we !== 1'b1 || a_ram_wr_addr !== 10'd5 || a_ram_di !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_drive: ready=%b we=%b addr=%0d di=%h required 1 1 5 deadbeef",
                     a_req_ready, a_ram_we, a_ram_wr_addr, a_ram_di);
        end
        step();
        set_a(1, 0, 10'd5, '0);
        #1;
        checks++;
        if (a_ram_re !== 1'b1 || a_ram_rd_addr !== 10'd5 || a_ram_we !== 1'b0) begin
            errors++;
            $display("FAIL rd_drive: re=%b addr=%0d we=%b required 1 5 0", a_ram_re, a_ram_rd_addr, a_ram_we);
        end
        step();
        set_a(0, 0, '0, '0);
        #1;
        checks++;
        if (a_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_latency_early: rsp_valid=%b required=0", a_rsp_valid);
        end
        step();
        checks++;
        if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rd_data: valid=%b data=%h required 1 deadbeef", a_rsp_valid, a_rsp_data);
        end
        step();
        checks++;
        if (a_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_single: rsp_valid=%b required=0", a_rsp_valid);
        end
    endtask

    task automatic test_forward();
        set_a(1, 0, 10'd7, '0);
        set_b(1, 1, 10'd7, 32'h1234);
        #1;
        checks++;
        if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1 || b_ram_we !== 1'b1) begin
            errors++;
            $display("FAIL fwd_accept: a_ready=%b b_ready=%b b_we=%b required 1 1 1", a_req_ready, b_req_ready, b_ram_we);
        end
        step();
        set_a(0, 0, '0, '0);
        set_b(0, 0, '0, '0);
        step();
        checks++;
        if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'h1234) begin
            errors++;
            $display("FAIL fwd_data: valid=%b data=%h required 1 00001234", a_rsp_valid, a_rsp_data);
        end
        step();
        set_a(1, 0, 10'd7, '0);
        step();
        set_a(0, 0, '0, '0);
        step();
        checks++;
        if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'h1234) begin
            errors++;
            $display("FAIL fwd_after: valid=%b data=%h required 1 00001234", a_rsp_valid, a_rsp_data);
        end
        step();
    endtask

    task automatic test_write_write();
        set_a(1, 1, 10'd3, 32'h11);
        set_b(1, 1, 10'd3, 32'h22);
        #1;
        checks++;
        if (a_ram_we !== 1'b1 || b_ram_we !== 1'b0 || a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ww_we: a_we=%b b_we=%b a_rdy=%b b_rdy=%b required 1 0 1 1",
                     a_ram_we, b_ram_we, a_req_ready, b_req_ready);
        end
        step();
        set_a(0, 0, '0, '0);
        set_b(1, 0, 10'd3, '0);
        step();
        set_b(0, 0, '0, '0);
        step();
        checks++;
        if (b_rsp_valid !== 1'b1 || b_rsp_data !== 32'h11) begin
            errors++;
            $display("FAIL ww_data: valid=%b data=%h required 1 00000011", b_rsp_valid, b_rsp_data);
        end
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            set_a(1, 1, AW'(i), 32'hB000_0000 + i);
            step();
        end
        set_a(0, 0, '0, '0);
        for (int k = 0; k < 18; k++) begin
            if (k < 16) set_b(1, 0, AW'(k), '0);
            else        set_b(0, 0, '0, '0);
            #1;
            if (k < 16) begin
                checks++;
                if (b_req_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready[%0d]: got=%b required=1", k, b_req_ready);
                end
            end
            if (k >= 2) begin
                checks++;
                if (b_rsp_valid !== 1'b1 || b_rsp_data !== 32'hB000_0000 + (k - 2)) begin
                    errors++;
                    $display("FAIL b2b_rsp[%0d]: valid=%b data=%h required 1 %h",
                             k, b_rsp_valid, b_rsp_data, 32'hB000_0000 + (k - 2));
                end
            end
            step();
        end
        checks++;
        if (b_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: rsp_valid=%b required=0", b_rsp_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [4:0] exp_ready;
        int         idx;
        exp_ready = 5'b00111;
        idx = 0;
        a_rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_a(1, 0, AW'(idx), '0);
            #1;
            checks++;
            if (a_req_ready !== exp_ready[k]) begin
                errors++;
                $display("FAIL bp_ready[%0d]: got=%b required=%b", k, a_req_ready, exp_ready[k]);
            end
            if (a_req_ready) idx++;
            step();
        end
        set_a(0, 0, '0, '0);
        checks++;
        if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'hB000_0000) begin
            errors++;
            $display("FAIL bp_hold: valid=%b data=%h required 1 b0000000", a_rsp_valid, a_rsp_data);
        end
        a_rsp_ready = 1'b1;
        #1;
        checks++;
        if (a_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_release: got=%b required=0", a_req_ready);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'hB000_0000 + k) begin
                errors++;
                $display("FAIL bp_drain[%0d]: valid=%b data=%h required 1 %h",
                         k, a_rsp_valid, a_rsp_data, 32'hB000_0000 + k);
            end
            step();
            if (k == 0) begin
                checks++;
                if (a_req_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_ready_return: got=%b required=1", a_req_ready);
                end
            end
        end
        checks++;
        if (a_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: rsp_valid=%b required=0", a_rsp_valid);
        end
    endtask

    task automatic test_reset_midstream();
        a_rsp_ready = 1'b0;
        set_a(1, 0, 10'd0, '0);
        step();
        set_a(1, 0, 10'd1, '0);
        step();
        set_a(0, 0, '0, '0);
        #1;
        checks++;
        if (a_rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: rsp_valid=%b required=1", a_rsp_valid);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (a_rsp_valid !== 1'b0 || a_ram_re !== 1'b0 || a_ram_we !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: valid=%b re=%b we=%b required 0 0 0", a_rsp_valid, a_ram_re, a_ram_we);
        end
        repeat (2) step();
        reset = 1'b1;
        a_rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
                errors++;
                $display("FAIL mid_after[%0d]: valid=%b ready=%b required 0 1", k, a_rsp_valid, a_req_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_forward();
        test_write_write();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_quad_frontend.md
Name: bram_quad_frontend

Overview:
- Request/response front-end for the quad-port block RAM: two independent lanes, A and B, each with a valid/ready request channel and a valid/ready read-response channel.
- Drives the RAM's per-port read and write address, data, and enable pins, and absorbs the RAM's fixed 1-cycle read latency into a credit-controlled response FIFO.
- Resolves cross-lane same-address hazards deterministically, so the RAM never returns X or has an ambiguous write order.

Parameters:
- ADDR_WIDTH, 10, RAM address width.
- DATA_WIDTH, 32, RAM word width.
- RSP_DEPTH, 3, per-lane response FIFO entries (minimum 2); also the per-lane credit limit.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- {a,b}_req_valid  in  1  request valid.
- {a,b}_req_ready  out  1  request accepted when valid && ready.
- {a,b}_req_write  in  1  1 = write, 0 = read.
- {a,b}_req_addr  in  ADDR_WIDTH  request address.
- {a,b}_req_data  in  DATA_WIDTH  write data.
- {a,b}_rsp_valid  out  1  read data available.
- {a,b}_rsp_ready  in  1  consumer accepts read data.
- {a,b}_rsp_data  out  DATA_WIDTH  read data.
- {a,b}_ram_rd_addr  out  ADDR_WIDTH  to RAM RD_ADDR_x.
- {a,b}_ram_wr_addr  out  ADDR_WIDTH  to RAM WR_ADDR_x.
- {a,b}_ram_di  out  DATA_WIDTH  to RAM DI_x.
- {a,b}_ram_we  out  1  to RAM WE_x.
- {a,b}_ram_re  out  1  to RAM RE_x.
- {a,b}_ram_do  in  DATA_WIDTH  from RAM DO_x; valid the cycle after RE_x.

Behaviour:
- Reset (async assert, sync release): all FIFOs empty; inflight flags 0; forward flags 0; rsp_valid 0; ram_we 0; ram_re 0; req_ready 1 once reset is released.
- Reads in flight or queued at reset assertion are discarded; no response is ever produced for them.
- Credit rule: per lane, occ = fifo_count + inflight (0..RSP_DEPTH); req_ready = (occ < RSP_DEPTH).
  - Registered only; no combinational path from rsp_ready to req_ready.
  - Writes consume the same ready but take no credit.
- RAM drive is combinational from the accepted request (fire = valid && ready):
  - Read: ram_re = 1, ram_rd_addr = req_addr.
  - Write: ram_we = 1, ram_wr_addr = req_addr, ram_di = req_data.
  - Each lane issues at most one operation per cycle, so the RAM's own same-port read/write collision never occurs.
- Cross-lane write/write, same address, same cycle: lane A's write wins; lane B's ram_we is forced to 0; both requests are still accepted.
- Cross-lane read/write, same address, same cycle: the read lane registers fwd = 1 and fwd_data = the other lane's write data (write-first semantics).
  - The RAM read still issues; its DO is ignored.
  - When both lanes write the address, the forwarded value is lane A's data.
- Read pipeline:
  - Cycle T: fire; inflight <= 1 at the edge.
  - Cycle T+1: push (fwd ? fwd_data : ram_do) into the FIFO; inflight returns to 0 unless another read fires.
  - Cycle T+2: rsp_valid = 1.
  - Latency is 2 cycles; throughput is 1 read/cycle per lane with rsp_ready held high.
- FIFO:
  - Circular; pointers wrap modulo RSP_DEPTH.
  - Push and pop in the same cycle keep the count unchanged.
  - Credits guarantee a push never hits a full FIFO (assertion in the bench).
  - rsp_data is stable while rsp_valid && !rsp_ready.
- Responses are returned in request order per lane; the lanes are fully independent apart from the hazard rules above.
- Writes produce no response.
- A read issued the cycle after a write to the same address on either lane returns the new data; the RAM is already updated.

Test Plan:
- Reset release, lane A writes 0xDEADBEEF to addr 5, then reads addr 5 -> a_rsp_data = 0xDEADBEEF, rsp_valid exactly 2 cycles after the read fires.
- Lane A reads addr 7 while lane B writes 0x1234 to addr 7 in the same cycle -> a_rsp_data = 0x1234, never X; a following read returns 0x1234.
- Both lanes write addr 3 (A = 0x11, B = 0x22) in one cycle -> b_ram_we = 0 that cycle; a later read of addr 3 returns 0x11.
- Back-to-back reads on lane B of addrs 0..15 with rsp_ready = 1 -> req_ready stays 1 and responses arrive in order, one per cycle.
- Lane A rsp_ready held 0 while reads are issued -> exactly RSP_DEPTH (3) reads accepted, then req_ready = 0; releasing rsp_ready drains 3 in-order responses and req_ready returns to 1 the next cycle.
- Reset asserted mid-stream with 2 reads outstanding -> rsp_valid drops immediately; after release, no stale response appears and req_ready = 1.
